// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Segment patterns and the hex-to-segment function for seg_scan_driver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_hex_decoder.sv
// ============================================================================
// Module   : seg_hex_decoder
// Purpose  : Combinational nibble to active-low seven-segment pattern
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexed seven-segment scanner with PWM brightness and
//            frame-synchronous shadow registers. Optional leading-zero
//            blanking when SEG_SCAN_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int BRIGHT_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     EN_MASK,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic                  FRAME
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [BRIGHT_W-1:0] PHASE_MAX = '1;
    localparam logic [DIG_W-1:0]    DIGIT_MAX = DIG_W'(DIGITS - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [BRIGHT_W-1:0] phase_q, phase_d;
    logic [DIG_W-1:0]    digit_q, digit_d;

    logic [4*DIGITS-1:0] sh_data_q;
    logic [DIGITS-1:0]   sh_dp_q;
    logic [DIGITS-1:0]   sh_en_q;
    logic [BRIGHT_W-1:0] sh_bright_q;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                sub_tick;
    logic                phase_wrap;
    logic                frame_wrap;
    logic                suppress;
    logic                lit;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_seg;

    assign sub_tick   = (presc_q == PRESC_MAX);
    assign phase_wrap = sub_tick && (phase_q == PHASE_MAX);
    assign frame_wrap = phase_wrap && (digit_q == DIGIT_MAX);

    always_comb begin
        presc_d = sub_tick ? '0 : presc_q + 1'b1;
        phase_d = sub_tick ? phase_q + 1'b1 : phase_q;
        digit_d = digit_q;
        // Explicit wrap so non-power-of-two digit counts never visit unused indices
        if (phase_wrap) begin
            digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
        end
    end

    assign cur_nibble = sh_data_q[{digit_q, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] upper_nz;
    logic              nz_acc;

    // upper_nz[i] is set when any nibble at index i or above is non-zero
    always_comb begin
        upper_nz = '0;
        nz_acc   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc      = nz_acc | (|sh_data_q[4*i +: 4]);
            upper_nz[i] = nz_acc;
        end
    end

    assign suppress = (digit_q != '0) && !upper_nz[digit_q];
`else
    assign suppress = 1'b0;
`endif

    assign lit = (phase_q != '0) && (phase_q <= sh_bright_q) &&
                 sh_en_q[digit_q] && !suppress;

    always_comb begin
        an_d = '1;
        if (lit) begin
            an_d[digit_q] = 1'b0;
        end
        seg_d = lit ? cur_seg : SEG_BLANK;
        dp_d  = lit ? ~sh_dp_q[digit_q] : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q     <= '0;
            phase_q     <= '0;
            digit_q     <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            sh_bright_q <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            digit_q <= digit_d;
            if (frame_wrap) begin
                sh_data_q   <= DATA;
                sh_dp_q     <= DP_IN;
                sh_en_q     <= EN_MASK;
                sh_bright_q <= BRIGHT;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_wrap;

endmodule

`default_nettype wire
